dcache_sram_nway: RTL and testbench

DCACHE_SRAM_NWAY -- requirements
Module: dcache_sram_nway

---
 rtl/dcache_sram_nway.sv | 130 +++++++++++++
 tb/tb_dcache_sram_nway.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_nway.sv
// rtl/dcache_sram_nway.sv - N-way set-associative data-cache tag/data SRAM with hit/victim select
// Optional build macro: DCACHE_SRAM_LRU_EN selects true-LRU replacement (default: round-robin).
module dcache_sram_nway #(
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256,
  localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [TAG_W+1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic [TAG_W+1:0]  tag_o,
  output logic [LINE_W-1:0] data_o,
  output logic              hit_o,
  output logic [WAY_W-1:0]  way_o
);

  // Stored tag word layout: {valid, dirty, tag}
  localparam int VALID_BIT = TAG_W + 1;

  logic [TAG_W+1:0]  r_tag  [SETS][WAYS];
  logic [LINE_W-1:0] r_data [SETS][WAYS];

  logic              w_hit_any;
  logic [WAY_W-1:0]  w_hit_way;
  logic              w_inv_any;
  logic [WAY_W-1:0]  w_inv_way;
  logic [WAY_W-1:0]  w_policy_way;
  logic [WAY_W-1:0]  w_victim;
  logic [WAY_W-1:0]  w_sel;
  logic              w_hit;

  // Scan the addressed set for a tag match and for an empty way; descending scan lets the lowest index win
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_way = '0;
    w_inv_any = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_tag[addr_i][w][VALID_BIT] &&
          (r_tag[addr_i][w][TAG_W-1:0] == tag_i[TAG_W-1:0])) begin
        w_hit_any = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_tag[addr_i][w][VALID_BIT]) begin
        w_inv_any = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
  end

  assign w_hit    = enable_i & w_hit_any;
  assign w_victim = w_inv_any ? w_inv_way : w_policy_way;
  assign w_sel    = w_hit ? w_hit_way : w_victim;

  assign hit_o  = w_hit;
  assign way_o  = w_sel;
  assign tag_o  = r_tag[addr_i][w_sel];
  assign data_o = r_data[addr_i][w_sel];

  // Tag/data storage: async clear, single-cycle write into the selected way
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_tag[s][w]  <= '0;
          r_data[s][w] <= '0;
        end
      end
    end else if (enable_i && write_i) begin
      r_tag[addr_i][w_sel]  <= tag_i;
      r_data[addr_i][w_sel] <= data_i;
    end
  end

`ifdef DCACHE_SRAM_LRU_EN
  logic [WAY_W-1:0] r_age [SETS][WAYS];

  // Oldest way (age WAYS-1) is the replacement candidate once the set is full
  always_comb begin
    w_policy_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_age[addr_i][w] == WAY_W'(WAYS - 1)) begin
        w_policy_way = WAY_W'(w);
      end
    end
  end

  // Touching a way makes it youngest; ways younger than its old age each grow one step older
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_age[s][w] <= WAY_W'(w);
        end
      end
    end else if (enable_i && (w_hit || write_i)) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == w_sel) begin
          r_age[addr_i][w] <= '0;
        end else if (r_age[addr_i][w] < r_age[addr_i][w_sel]) begin
          r_age[addr_i][w] <= r_age[addr_i][w] + 1'b1;
        end
      end
    end
  end
`else
  logic [WAY_W-1:0] r_ptr [SETS];

  assign w_policy_way = r_ptr[addr_i];

  // Round-robin pointer advances on every fill (write miss); wraps naturally since WAYS is a power of 2
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        r_ptr[s] <= '0;
      end
    end else if (enable_i && write_i && !w_hit) begin
      r_ptr[addr_i] <= r_ptr[addr_i] + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb/tb_dcache_sram_nway.sv - directed scoreboard bench for dcache_sram_nway (2-way and 4-way instances)
module tb_dcache_sram_nway;

  localparam logic [24:0] V   = 25'h100_0000;
  localparam logic [24:0] DRT = 25'h080_0000;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [3:0]   addr_i = '0;
  logic [24:0]  tag_i = '0;
  logic [255:0] data_i = '0;
  logic         enable_i = 1'b0;
  logic         write_i = 1'b0;

  logic [24:0]  tag2_o, tag4_o;
  logic [255:0] data2_o, data4_o;
  logic         hit2_o, hit4_o;
  logic [0:0]   way2_o;
  logic [1:0]   way4_o;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int           dut;
    string        nm;
    logic         hit;
    logic [2:0]   way;
    logic [24:0]  tag;
    logic [255:0] data;
  } exp_t;

  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  dcache_sram_nway #(.WAYS(2), .SETS(16), .TAG_W(23), .LINE_W(256)) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i),
    .enable_i(enable_i), .write_i(write_i),
    .tag_o(tag2_o), .data_o(data2_o), .hit_o(hit2_o), .way_o(way2_o)
  );

  dcache_sram_nway #(.WAYS(4), .SETS(16), .TAG_W(23), .LINE_W(256)) u_dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i),
    .enable_i(enable_i), .write_i(write_i),
    .tag_o(tag4_o), .data_o(data4_o), .hit_o(hit4_o), .way_o(way4_o)
  );

  function automatic logic [255:0] mk(input int n);
    return {8{32'hC0DE_0000 + 32'(n)}};
  endfunction

  task automatic drive(input logic [3:0] a, input logic [24:0] t, input logic [255:0] d,
                       input logic en, input logic wr);
    @(negedge clk_i);
    addr_i = a; tag_i = t; data_i = d; enable_i = en; write_i = wr;
  endtask

  task automatic push(input int dut, input string nm, input logic h, input logic [2:0] w,
                      input logic [24:0] t, input logic [255:0] d);
    sb.push_back('{dut: dut, nm: nm, hit: h, way: w, tag: t, data: d});
  endtask

  task automatic chk(input string nm, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 2) begin
        chk({e.nm, ".hit2"},  256'(hit2_o),          256'(e.hit));
        chk({e.nm, ".way2"},  256'({2'b00, way2_o}), 256'(e.way));
        chk({e.nm, ".tag2"},  256'(tag2_o),          256'(e.tag));
        chk({e.nm, ".data2"}, data2_o,               e.data);
      end else begin
        chk({e.nm, ".hit4"},  256'(hit4_o),          256'(e.hit));
        chk({e.nm, ".way4"},  256'({1'b0, way4_o}),  256'(e.way));
        chk({e.nm, ".tag4"},  256'(tag4_o),          256'(e.tag));
        chk({e.nm, ".data4"}, data4_o,               e.data);
      end
    end
  endtask

  initial begin
    // reset state while rst_i held
    drive(4'd3, 25'h1234, '0, 1'b1, 1'b0);
    push(2, "rst_read", 1'b0, 3'd0, '0, '0);
    push(4, "rst_read", 1'b0, 3'd0, '0, '0);
    sb_check();
    @(posedge clk_i);
    #2 rst_i = 1'b0;

    // after reset, before any write
    drive(4'd3, 25'h1234, '0, 1'b1, 1'b0);
    push(2, "post_rst", 1'b0, 3'd0, '0, '0);
    sb_check();

    // first write into empty set 3 goes to way 0
    drive(4'd3, V | 25'h00A, mk(1), 1'b1, 1'b1);
    push(2, "wr_a_pre", 1'b0, 3'd0, '0, '0);
    sb_check();

    drive(4'd3, 25'h00A, '0, 1'b1, 1'b0);
    push(2, "rd_a", 1'b1, 3'd0, V | 25'h00A, mk(1));
    sb_check();

    // fill with 0x00B lands in lowest invalid way 1
    drive(4'd3, V | 25'h00B, mk(3), 1'b1, 1'b1);
    push(2, "wr_b_pre", 1'b0, 3'd1, '0, '0);
    sb_check();

    // write-hit 0x00A with dirty set
    drive(4'd3, V | DRT | 25'h00A, mk(2), 1'b1, 1'b1);
    push(2, "wrhit_a_pre", 1'b1, 3'd0, V | 25'h00A, mk(1));
    sb_check();

    drive(4'd3, 25'h00C, '0, 1'b1, 1'b0);
`ifdef DCACHE_SRAM_LRU_EN
    push(2, "rd_c_victim", 1'b0, 3'd1, V | 25'h00B, mk(3));
`else
    push(2, "rd_c_victim", 1'b0, 3'd0, V | DRT | 25'h00A, mk(2));
`endif
    sb_check();

    drive(4'd3, 25'h00A, '0, 1'b1, 1'b0);
    push(2, "rd_a_dirty", 1'b1, 3'd0, V | DRT | 25'h00A, mk(2));
    sb_check();

    // disabled access: no hit, victim shown
    drive(4'd3, 25'h00A, '0, 1'b0, 1'b1);
`ifdef DCACHE_SRAM_LRU_EN
    push(2, "disabled", 1'b0, 3'd1, V | 25'h00B, mk(3));
`else
    push(2, "disabled", 1'b0, 3'd0, V | DRT | 25'h00A, mk(2));
`endif
    sb_check();

    // disabled write above must not have stored anything
    drive(4'd3, 25'h00B, '0, 1'b1, 1'b0);
    push(2, "rd_b_after_dis", 1'b1, 3'd1, V | 25'h00B, mk(3));
    sb_check();

    // neighbouring set untouched
    drive(4'd4, 25'h00A, '0, 1'b1, 1'b0);
    push(2, "other_set", 1'b0, 3'd0, '0, '0);
    sb_check();

    // 4-way replacement sequence in set 0
    for (int i = 1; i <= 4; i++) begin
      drive(4'd0, V | 25'(i), mk(16 + i), 1'b1, 1'b1);
      push(4, $sformatf("fill4_%0d", i), 1'b0, 3'(i - 1), '0, '0);
      sb_check();
    end
    drive(4'd0, 25'h1, '0, 1'b1, 1'b0);
    push(4, "rd4_1", 1'b1, 3'd0, V | 25'h1, mk(17));
    sb_check();
    drive(4'd0, 25'h5, '0, 1'b1, 1'b0);
`ifdef DCACHE_SRAM_LRU_EN
    push(4, "rd4_5_victim", 1'b0, 3'd1, V | 25'h2, mk(18));
`else
    push(4, "rd4_5_victim", 1'b0, 3'd0, V | 25'h1, mk(17));
`endif
    sb_check();

    // reset arriving mid-write to set 5
    drive(4'd5, V | 25'h077, mk(40), 1'b1, 1'b1);
    sb_check();
    drive(4'd5, V | 25'h077, mk(41), 1'b1, 1'b1);
    push(2, "pre_rst_hit", 1'b1, 3'd0, V | 25'h077, mk(40));
    sb_check();
    #1 rst_i = 1'b1;
    push(2, "mid_rst", 1'b0, 3'd0, '0, '0);
    push(4, "mid_rst", 1'b0, 3'd0, '0, '0);
    sb_check();
    @(posedge clk_i);
    #2 rst_i = 1'b0;

    drive(4'd5, 25'h077, '0, 1'b1, 1'b0);
    push(2, "post_rst_set5", 1'b0, 3'd0, '0, '0);
    sb_check();
    drive(4'd3, 25'h00A, '0, 1'b1, 1'b0);
    push(2, "post_rst_set3", 1'b0, 3'd0, '0, '0);
    sb_check();
    drive(4'd0, 25'h1, '0, 1'b1, 1'b0);
    push(4, "post_rst_set0", 1'b0, 3'd0, '0, '0);
    sb_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
